// File: rtl/mac_load_sequencer.sv
// mac_load_sequencer: loads the B vector and NUM_ROWS A rows from mem_wrapper
// into the vectored MAC, runs the execute phase, drains the pipeline and
// reports done. Also flags inconsistent FIFO full/empty status (sticky).
module mac_load_sequencer #(
   parameter int DATA_WIDTH   = 8,
   parameter int NUM_ROWS     = 8,
   parameter int ADDR_WIDTH   = 32,
   parameter int B_ADDR       = 0,
   parameter int A_BASE       = 1,
   parameter int DRAIN_CYCLES = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   output logic [ADDR_WIDTH-1:0]          mem_address,
   output logic                           mem_read,
   input  logic                           mem_waitrequest,
   input  logic [NUM_ROWS*DATA_WIDTH-1:0] mem_readdata,
   input  logic                           mem_readdatavalid,
   output logic [NUM_ROWS*DATA_WIDTH-1:0] b_vec,
   output logic [NUM_ROWS*DATA_WIDTH-1:0] fifo_datain,
   output logic                           fifo_wren,
   input  logic                           fifo_full,
   input  logic                           fifo_empty,
   output logic                           fifo_rden,
   output logic                           mac_en,
   output logic                           mac_clr,
   output logic                           busy,
   output logic                           done,
   output logic                           error
);

   localparam int ROW_W   = $clog2(NUM_ROWS + 1);
   localparam int CNT_MAX = (NUM_ROWS > DRAIN_CYCLES) ? NUM_ROWS : DRAIN_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_CLR,
      S_RD_B,
      S_WT_B,
      S_RD_A,
      S_WT_A,
      S_WR_A,
      S_EXEC,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t             state, state_d;
   logic [ROW_W-1:0]   row;
   logic [CNT_W-1:0]   cnt;

   // State register, row/phase counters, data latches and sticky error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         row         <= '0;
         cnt         <= '0;
         b_vec       <= '0;
         fifo_datain <= '0;
         error       <= 1'b0;
      end else begin
         state <= state_d;
         case (state)
            S_CLR: begin
               row <= '0;
               cnt <= '0;
            end
            S_WT_B: begin
               if (mem_readdatavalid) b_vec <= mem_readdata;
            end
            S_WT_A: begin
               if (mem_readdatavalid) fifo_datain <= mem_readdata;
            end
            S_WR_A: begin
               row <= row + ROW_W'(1);
               // FIFO must not report full before the final row is written.
               if (fifo_full && (row < ROW_W'(NUM_ROWS - 1))) error <= 1'b1;
            end
            S_EXEC: begin
               // First execute cycle directly follows the last write: FIFO must be full.
               if ((cnt == '0) && !fifo_full) error <= 1'b1;
               if (cnt == CNT_W'(NUM_ROWS - 1)) cnt <= '0;
               else                             cnt <= cnt + CNT_W'(1);
            end
            S_DRAIN: begin
               cnt <= cnt + CNT_W'(1);
               // Check emptiness on the cycle that enters DONE.
               if ((cnt == CNT_W'(DRAIN_CYCLES - 1)) && !fifo_empty) error <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Next-state and strobe decode; all strobes are pure functions of state.
   always_comb begin
      state_d     = state;
      mem_read    = 1'b0;
      mem_address = '0;
      fifo_wren   = 1'b0;
      fifo_rden   = 1'b0;
      mac_clr     = 1'b0;
      done        = 1'b0;
      busy        = 1'b1;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_d = S_CLR;
         end
         S_CLR: begin
            mac_clr = 1'b1;
            state_d = S_RD_B;
         end
         S_RD_B: begin
            mem_read    = 1'b1;
            mem_address = ADDR_WIDTH'(B_ADDR);
            if (!mem_waitrequest) state_d = S_WT_B;
         end
         S_WT_B: begin
            if (mem_readdatavalid) state_d = S_RD_A;
         end
         S_RD_A: begin
            mem_read    = 1'b1;
            mem_address = ADDR_WIDTH'(A_BASE) + ADDR_WIDTH'(row);
            if (!mem_waitrequest) state_d = S_WT_A;
         end
         S_WT_A: begin
            if (mem_readdatavalid) state_d = S_WR_A;
         end
         S_WR_A: begin
            fifo_wren = 1'b1;
            // row is incremented on this edge, so NUM_ROWS-1 here means the last row.
            if (row == ROW_W'(NUM_ROWS - 1)) state_d = S_EXEC;
            else                             state_d = S_RD_A;
         end
         S_EXEC: begin
            fifo_rden = 1'b1;
            if (cnt == CNT_W'(NUM_ROWS - 1)) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (cnt == CNT_W'(DRAIN_CYCLES - 1)) state_d = S_DONE;
         end
         S_DONE: begin
            busy = 1'b0;
            done = 1'b1;
            if (start) state_d = S_CLR;
         end
         default: begin
            busy    = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   assign mac_en = fifo_rden;

endmodule

// File: tb/tb_mac_load_sequencer.sv
// Scoreboard bench for mac_load_sequencer with a behavioural memory/FIFO model.
module tb_mac_load_sequencer;

   localparam int DW = 8;
   localparam int NR = 8;
   localparam int AW = 32;
   localparam int DC = 8;
   localparam int RW = NR * DW;
   localparam logic [RW-1:0] B_ROW = 64'h0807060504030201;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] mem_address;
   logic          mem_read;
   logic          mem_waitrequest;
   logic [RW-1:0] mem_readdata;
   logic          mem_readdatavalid;
   logic [RW-1:0] b_vec;
   logic [RW-1:0] fifo_datain;
   logic          fifo_wren;
   logic          fifo_full;
   logic          fifo_empty;
   logic          fifo_rden;
   logic          mac_en;
   logic          mac_clr;
   logic          busy;
   logic          done;
   logic          error;

   mac_load_sequencer #(
      .DATA_WIDTH(DW), .NUM_ROWS(NR), .ADDR_WIDTH(AW),
      .B_ADDR(0), .A_BASE(1), .DRAIN_CYCLES(DC)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .mem_address(mem_address), .mem_read(mem_read),
      .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
      .mem_readdatavalid(mem_readdatavalid),
      .b_vec(b_vec), .fifo_datain(fifo_datain), .fifo_wren(fifo_wren),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_rden(fifo_rden),
      .mac_en(mac_en), .mac_clr(mac_clr), .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [RW-1:0] b;
      logic          err;
   } run_t;

   logic [RW-1:0] exp_rows[$];
   run_t          exp_runs[$];

   int unsigned n_pass = 0;
   int unsigned n_total = 0;

   // memory / FIFO model knobs and observations
   logic [AW-1:0] stall_addr = '1;
   int            stall_left = 0;
   int            stall_seen = 0;
   int            b_extra = 0;
   int            bwait_bad = 0;
   int            accepts = 0;
   bit            force_full = 1'b0;

   task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [RW-1:0] row_of(input logic [AW-1:0] a);
      logic [7:0] byte_v;
      byte_v = 8'(8'h11 * a[7:0]);
      if (a == '0) return B_ROW;
      return {NR{byte_v}};
   endfunction

   // Memory responder (one outstanding read) and FIFO occupancy model, driven on negedge.
   initial begin : mem_model
      bit            pending;
      logic [AW-1:0] p_addr;
      int            lat;
      int            fcnt;
      pending = 1'b0; p_addr = '0; lat = 0; fcnt = 0;
      forever begin
         @(negedge clk);
         mem_readdatavalid = 1'b0;
         mem_waitrequest   = 1'b0;
         mem_readdata      = 64'hDEADBEEFCAFEF00D;
         if (rst) begin
            pending    = 1'b0;
            fcnt       = 0;
            fifo_full  = 1'b0;
            fifo_empty = 1'b1;
         end else begin
            fifo_full  = (fcnt == NR) || force_full;
            fifo_empty = (fcnt == 0);
            if (fifo_wren) fcnt++;
            if (fifo_rden) fcnt--;
            if (pending) begin
               if (lat == 0) begin
                  mem_readdatavalid = 1'b1;
                  mem_readdata      = row_of(p_addr);
                  pending           = 1'b0;
               end else begin
                  lat--;
                  if (p_addr == '0 && (!busy || fifo_wren)) bwait_bad++;
               end
            end else if (mem_read) begin
               if (mem_address == stall_addr && stall_left > 0) begin
                  mem_waitrequest = 1'b1;
                  stall_left--;
                  stall_seen++;
               end else begin
                  pending = 1'b1;
                  p_addr  = mem_address;
                  lat     = (p_addr == '0) ? b_extra : 0;
                  accepts++;
               end
            end
         end
      end
   end

   // Monitor: pops expected rows on each fifo_wren and a run record on each done rise.
   initial begin : monitor
      int   wren_cnt, rden_cnt, since_rden, clr_cnt, en_bad, gap;
      bit   done_q;
      run_t r;
      wren_cnt = 0; rden_cnt = 0; since_rden = 0; clr_cnt = 0; en_bad = 0; gap = 0; done_q = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            wren_cnt = 0; rden_cnt = 0; since_rden = 0; clr_cnt = 0; en_bad = 0; gap = 0;
            done_q = 0;
         end else begin
            if (mac_en !== fifo_rden) en_bad++;
            if (mac_clr) clr_cnt++;
            if (fifo_wren) begin
               if (exp_rows.size() == 0) check("wren_unexpected", 1, 0);
               else check("fifo_datain", fifo_datain, exp_rows.pop_front());
               wren_cnt++;
            end
            if (fifo_rden) begin
               if (rden_cnt > 0 && since_rden > 0) gap++;
               rden_cnt++;
               since_rden = 0;
            end else begin
               since_rden++;
            end
            if (done && !done_q) begin
               if (exp_runs.size() == 0) begin
                  check("done_unexpected", 1, 0);
               end else begin
                  r = exp_runs.pop_front();
                  check("b_vec", b_vec, r.b);
                  check("error", error, r.err);
                  check("wren_count", wren_cnt, NR);
                  check("rden_count", rden_cnt, NR);
                  check("rden_gap", gap, 0);
                  check("drain_to_done", since_rden, DC + 1);
                  check("mac_clr_pulses", clr_cnt, 1);
                  check("mac_en_eq_rden", en_bad, 0);
               end
               wren_cnt = 0; rden_cnt = 0; clr_cnt = 0; en_bad = 0; gap = 0;
            end
            done_q = done;
         end
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic begin_run(input logic exp_err);
      run_t r;
      for (int k = 1; k <= NR; k++) exp_rows.push_back(row_of(AW'(k)));
      r.b = B_ROW;
      r.err = exp_err;
      exp_runs.push_back(r);
      accepts = 0;
      pulse_start();
   endtask

   task automatic wait_done(input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!seen) check("done_timeout", 0, 1);
   endtask

   task automatic wait_cond_addr(input logic [AW-1:0] a, input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (mem_read && mem_address == a) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check("addr_timeout", 0, 1);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      int rd_seen;
      bit hit;
      rst = 1'b1;
      start = 1'b0;
      mem_waitrequest = 1'b0;
      mem_readdatavalid = 1'b0;
      mem_readdata = '0;
      fifo_full = 1'b0;
      fifo_empty = 1'b1;

      // reset state
      repeat (2) @(negedge clk);
      check("rst_strobes", {mem_read, fifo_wren, fifo_rden, mac_en, mac_clr, busy, done, error}, 0);
      check("rst_mem_address", mem_address, 0);
      check("rst_b_vec", b_vec, 0);
      check("rst_fifo_datain", fifo_datain, 0);

      // start held while reset is still asserted is not accepted
      start = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("start_in_reset_ignored", busy, 0);

      // 1: zero-wait run
      begin_run(1'b0);
      check("busy_after_start", busy, 1);
      wait_done(300);
      check("accepts_plain", accepts, NR + 1);

      // 2: waitrequest stall on row address 4
      stall_addr = 4; stall_left = 5; stall_seen = 0;
      begin_run(1'b0);
      wait_done(300);
      check("stall_cycles_held", stall_seen, 5);
      check("accepts_stall", accepts, NR + 1);
      stall_addr = '1;

      // 3: slow B read
      b_extra = 20; bwait_bad = 0;
      begin_run(1'b0);
      wait_done(300);
      check("b_wait_no_wren_busy", bwait_bad, 0);
      b_extra = 0;

      // 4: reset during EXEC cycle 4
      begin_run(1'b0);
      rd_seen = 0;
      hit = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (fifo_rden) rd_seen++;
         if (rd_seen == 4) begin
            hit = 1'b1;
            break;
         end
      end
      check("exec_reached", hit, 1);
      #1 rst = 1'b1;
      #1;
      check("abort_strobes", {mem_read, fifo_wren, fifo_rden, mac_en, mac_clr, busy, done, error}, 0);
      check("abort_b_vec", b_vec, 0);
      check("abort_fifo_datain", fifo_datain, 0);
      exp_rows.delete();
      exp_runs.delete();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("abort_quiet", {mem_read, fifo_wren, fifo_rden, mac_clr, busy}, 0);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      begin_run(1'b0);
      wait_done(300);
      check("accepts_after_abort", accepts, NR + 1);

      // 5: start ignored in RD_A and DRAIN, honoured in DONE
      begin_run(1'b0);
      wait_cond_addr(3, 300);
      pulse_start();
      hit = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (fifo_rden) hit = 1'b1;
         else if (hit) break;
      end
      pulse_start();
      wait_done(300);
      check("accepts_ignored_starts", accepts, NR + 1);
      begin_run(1'b0);
      check("done_clears", done, 0);
      wait_done(300);
      check("accepts_second_run", accepts, NR + 1);

      // 6: fifo_full forced before row 5
      exp_rows.delete();
      begin_run(1'b1);
      wait_cond_addr(6, 300);
      force_full = 1'b1;
      hit = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (fifo_wren) begin
            hit = 1'b1;
            break;
         end
      end
      @(negedge clk);
      force_full = 1'b0;
      wait_done(300);
      repeat (3) @(negedge clk);
      check("error_sticky", error, 1);
      check("done_sticky", done, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mac_load_sequencer.md
Name: mac_load_sequencer

Overview:
- Top-level controller that sequences the matrix-vector MAC flow.
- Reads row 0 (B vector) from mem_wrapper into a B register, then rows 1..NUM_ROWS (A matrix) one at a time into the vectored MAC FIFOs.
- Runs the MAC execute phase, drains the pipeline, and signals done.
- Sits between mem_wrapper and vectored_mac_fifo, replacing ad-hoc top-level FSM logic.

Parameters:
- DATA_WIDTH, 8: byte width of each vector element.
- NUM_ROWS, 8: number of A rows and FIFO depth; also the number of elements per row.
- ADDR_WIDTH, 32: mem_wrapper address width.
- B_ADDR, 0: row address of the B vector.
- A_BASE, 1: row address of the first A row.
- DRAIN_CYCLES, 8: cycles after the last rden before done, covering MAC pipeline latency.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  single-cycle pulse; begins a run when idle or done.
- mem_address  out  ADDR_WIDTH  row address to mem_wrapper.
- mem_read  out  1  read request.
- mem_waitrequest  in  1  memory stall; request is held while high.
- mem_readdata  in  NUM_ROWS*DATA_WIDTH  returned row.
- mem_readdatavalid  in  1  mem_readdata valid this cycle.
- b_vec  out  NUM_ROWS*DATA_WIDTH  registered B vector to MAC Bin.
- fifo_datain  out  NUM_ROWS*DATA_WIDTH  registered A row, byte i to FIFO i.
- fifo_wren  out  1  write strobe to all FIFOs.
- fifo_full  in  1  full flag of the last FIFO.
- fifo_empty  in  1  empty flag of the last FIFO.
- fifo_rden  out  1  read strobe to all FIFOs.
- mac_en  out  1  MAC enable, equal to fifo_rden.
- mac_clr  out  1  accumulator clear pulse.
- busy  out  1  high from start acceptance until done.
- done  out  1  sticky high until the next accepted start or reset.
- error  out  1  sticky; FIFO full/empty mismatch detected.

Behaviour:
- Reset (async, rst=1):
  - state = IDLE.
  - All outputs 0, including b_vec and fifo_datain.
  - Row counter = 0.
  - Reset mid-run aborts immediately; no further memory or FIFO strobes are issued.
- States:
  - IDLE: on start, go to CLR.
  - CLR: mac_clr=1 for exactly 1 cycle; go to RD_B.
  - RD_B: mem_read=1, mem_address=B_ADDR. Hold both while mem_waitrequest=1. On the first cycle with mem_waitrequest=0, go to WT_B.
  - WT_B: mem_read=0. On mem_readdatavalid, latch b_vec = mem_readdata; go to RD_A.
  - RD_A: mem_read=1, mem_address = A_BASE + row. Same waitrequest rule as RD_B; go to WT_A.
  - WT_A: on mem_readdatavalid, latch fifo_datain and pulse fifo_wren the next cycle (state WR_A, 1 cycle); row++.
    - If row reaches NUM_ROWS, go to EXEC.
    - Otherwise go to RD_A.
  - EXEC: fifo_rden = mac_en = 1 for exactly NUM_ROWS consecutive cycles; go to DRAIN.
  - DRAIN: count DRAIN_CYCLES cycles, no strobes; go to DONE.
  - DONE: done=1, busy=0. On start, clear done and go to CLR.
- Memory handshake:
  - Only one outstanding read at a time.
  - Latency from mem_read acceptance to readdatavalid is unbounded; the FSM waits indefinitely.
  - mem_readdatavalid in any state other than WT_B or WT_A is ignored.
- Data and width rules:
  - Row data is stored unmodified; byte i = mem_readdata[DATA_WIDTH*i +: DATA_WIDTH].
  - mem_address is zero-extended row arithmetic; the row counter is $clog2(NUM_ROWS+1) bits.
- Boundary and error conditions (error is sticky; state flow is unaffected):
  - fifo_full=1 when entering WR_A with row < NUM_ROWS-1 sets error, and the write is still issued.
  - fifo_full=0 after the last WR_A sets error.
  - fifo_empty=0 on entry to DONE sets error.
- start handling:
  - start is ignored in all states other than IDLE and DONE.
  - start coincident with reset deassertion is ignored.
- Throughput: with zero wait states and 1-cycle read latency, the load phase is 3 cycles per row.

Test Plan:
- Zero-wait memory, B row = 0x0807060504030201, A rows = 0x11*(r+1) per byte -> b_vec latched; 8 fifo_wren pulses carrying 0x1111..11 through 0x8888..88; 8 rden cycles; done rises 1 cycle after 8 drain cycles; error=0.
- mem_waitrequest held high 5 cycles on row 3 -> mem_read and mem_address=4 stable for all 5 cycles; exactly one request accepted; output data is unchanged versus the no-stall case.
- readdatavalid delayed 20 cycles on the B read -> no fifo_wren until b_vec is latched; busy stays 1 throughout.
- rst pulsed during EXEC cycle 4 -> all outputs 0 the same cycle; state IDLE; a later start completes a full clean run.
- start pulsed during RD_A and during DRAIN -> ignored. start in DONE -> done clears next cycle, mac_clr pulses once, and a second run reads B_ADDR again.
- fifo_full forced 1 before row 5 -> error=1 and stays 1 through DONE; sequence still ends with done=1.
